// File: rtl/plru_ctrl_if.sv
// ---------------------------------------------------------------------------
// plru_ctrl_if
// Purpose : bundles the request/response, flush and PLRU-array port signals
//           of plru_ctrl so the controller and its environment connect through
//           a single handle.
// Ports   : none (signal bundle only).
//   slave  : controller view (drives req_ready, rsp_*, flush_busy/done, lru_*).
//   master : requester/array view (drives req_*, flush_req, lru_dout0).
// ---------------------------------------------------------------------------
interface plru_ctrl_if #(
  parameter int S_INDEX = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [S_INDEX-1:0] req_index;
  logic               req_update;
  logic [1:0]         req_way;

  logic               rsp_valid;
  logic [1:0]         rsp_victim;

  logic               flush_req;
  logic               flush_busy;
  logic               flush_done;

  logic               lru_csb0;
  logic               lru_web0;
  logic [S_INDEX-1:0] lru_addr0;
  logic [2:0]         lru_dout0;

  logic               lru_csb1;
  logic               lru_web1;
  logic [S_INDEX-1:0] lru_addr1;
  logic [2:0]         lru_din1;

  modport slave (
    input  req_valid, req_index, req_update, req_way, flush_req, lru_dout0,
    output req_ready, rsp_valid, rsp_victim, flush_busy, flush_done,
           lru_csb0, lru_web0, lru_addr0, lru_csb1, lru_web1, lru_addr1, lru_din1
  );

  modport master (
    output req_valid, req_index, req_update, req_way, flush_req, lru_dout0,
    input  req_ready, rsp_valid, rsp_victim, flush_busy, flush_done,
           lru_csb0, lru_web0, lru_addr0, lru_csb1, lru_web1, lru_addr1, lru_din1
  );
endinterface

// File: rtl/plru_ctrl.sv
// ---------------------------------------------------------------------------
// plru_ctrl
// Purpose : 4-way tree pseudo-LRU controller for a set-associative cache.
//           Each request reads the 3-bit PLRU state of one set from an external
//           array (port 0), reports the victim way one cycle later, and on an
//           update writes the new state back (port 1). A flush sweeps every set
//           back to 3'b000.
// Ports   :
//   clk    in  single clock, rising edge
//   rst_n  in  synchronous active-low reset
//   bus    plru_ctrl_if.slave
//     req_valid/req_ready/req_index/req_update/req_way  request handshake
//     rsp_valid/rsp_victim                              response strobe + victim
//     flush_req/flush_busy/flush_done                   flush control
//     lru_csb0/lru_web0/lru_addr0/lru_dout0             array read port
//     lru_csb1/lru_web1/lru_addr1/lru_din1              array write port
//
// state  | meaning
// IDLE   | serving lookup/update requests
// FLUSH  | writing 3'b000 to one set per cycle, requests blocked
// ---------------------------------------------------------------------------
module plru_ctrl #(
  parameter int S_INDEX = 4
) (
  input logic         clk,
  input logic         rst_n,
  plru_ctrl_if.slave  bus
);

  localparam logic [S_INDEX-1:0] LAST_SET = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [S_INDEX-1:0] r_cnt;
  logic [S_INDEX-1:0] w_cnt_nxt;

  logic               r_s2_valid;
  logic [S_INDEX-1:0] r_s2_index;
  logic               r_s2_update;
  logic [1:0]         r_s2_way;

  logic               w_req_ready;
  logic               w_accept;
  logic               w_flush_busy;
  logic               w_flush_done;
  logic               w_flush_wr;
  logic               w_s2_wr;

  logic [2:0]         w_rd_state;
  logic [1:0]         w_victim;
  logic [2:0]         w_upd_state;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and control outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_req_ready  = 1'b0;
    w_flush_busy = 1'b0;
    w_flush_done = 1'b0;
    w_flush_wr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Blocking on flush_req in the accept cycle keeps S2 empty once the
        // sweep starts, so port 1 only ever has one writer.
        w_req_ready = rst_n && !bus.flush_req;
        if (bus.flush_req) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = '0;
        end
      end
      ST_FLUSH: begin
        w_flush_busy = 1'b1;
        // A reset during the sweep abandons it: no final write, no done.
        w_flush_wr   = rst_n;
        if (r_cnt == LAST_SET) begin
          w_state_nxt  = ST_IDLE;
          w_flush_done = rst_n;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_accept = bus.req_valid && w_req_ready;

  // ---------------------------------------------------------------------
  // S1 -> S2 pipeline register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_index  <= '0;
      r_s2_update <= 1'b0;
      r_s2_way    <= '0;
    end else begin
      r_s2_valid <= w_accept;
      if (w_accept) begin
        r_s2_index  <= bus.req_index;
        r_s2_update <= bus.req_update;
        r_s2_way    <= bus.req_way;
      end
    end
  end

  // ---------------------------------------------------------------------
  // S2: victim selection and state update from the array read data.
  // Back-to-back same-set accesses see the previous write because the
  // array forwards port 1 onto port 0.
  // ---------------------------------------------------------------------
  assign w_rd_state = bus.lru_dout0;

  always_comb begin
    w_victim = 2'd0;
    if (w_rd_state[0]) begin
      w_victim = {1'b1, w_rd_state[2]};
    end else begin
      w_victim = {1'b0, w_rd_state[1]};
    end
  end

  // Point the tree away from the accessed way; the other subtree bit is kept.
  always_comb begin
    w_upd_state = w_rd_state;
    case (r_s2_way)
      2'd0: w_upd_state = {w_rd_state[2], 1'b1, 1'b1};
      2'd1: w_upd_state = {w_rd_state[2], 1'b0, 1'b1};
      2'd2: w_upd_state = {1'b1, w_rd_state[1], 1'b0};
      2'd3: w_upd_state = {1'b0, w_rd_state[1], 1'b0};
      default: w_upd_state = w_rd_state;
    endcase
  end

  assign w_s2_wr = r_s2_valid && r_s2_update;

  // ---------------------------------------------------------------------
  // Array port 1 mux: S2 write-back or flush write (never both).
  // ---------------------------------------------------------------------
  always_comb begin
    bus.lru_csb1  = 1'b1;
    bus.lru_web1  = 1'b1;
    bus.lru_addr1 = r_s2_index;
    bus.lru_din1  = w_upd_state;
    if (w_s2_wr) begin
      bus.lru_csb1 = 1'b0;
      bus.lru_web1 = 1'b0;
    end else if (w_flush_wr) begin
      bus.lru_csb1  = 1'b0;
      bus.lru_web1  = 1'b0;
      bus.lru_addr1 = r_cnt;
      bus.lru_din1  = 3'b000;
    end
  end

  // ---------------------------------------------------------------------
  // Remaining outputs
  // ---------------------------------------------------------------------
  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = r_s2_valid;
  assign bus.rsp_victim = r_s2_valid ? w_victim : 2'd0;
  assign bus.flush_busy = w_flush_busy;
  assign bus.flush_done = w_flush_done;

  assign bus.lru_csb0  = !w_accept;
  assign bus.lru_web0  = 1'b1;
  assign bus.lru_addr0 = bus.req_index;

endmodule

// File: tb/tb_plru_ctrl.sv
module tb_plru_ctrl;
  localparam int S_INDEX  = 4;
  localparam int NUM_SETS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  plru_ctrl_if #(.S_INDEX(S_INDEX)) bus ();

  plru_ctrl #(.S_INDEX(S_INDEX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // PLRU array model: registered read, same-set write forwarded to the read.
  logic [2:0] mem [NUM_SETS] = '{default: 3'b000};
  always @(posedge clk) begin
    if (!bus.lru_csb1 && !bus.lru_web1) mem[bus.lru_addr1] <= bus.lru_din1;
    if (!bus.lru_csb0) begin
      if (!bus.lru_csb1 && !bus.lru_web1 && bus.lru_addr1 == bus.lru_addr0)
        bus.lru_dout0 <= bus.lru_din1;
      else
        bus.lru_dout0 <= mem[bus.lru_addr0];
    end
  end

  // Reference PLRU state per set and response scoreboard.
  logic [2:0] ref_st [NUM_SETS] = '{default: 3'b000};

  typedef struct {
    logic [1:0]         victim;
    logic               upd;
    logic [S_INDEX-1:0] idx;
    logic [2:0]         din;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  function automatic logic [1:0] ref_victim(input logic [2:0] st);
    if (st[0] == 1'b0) return {1'b0, st[1]};
    return {1'b1, st[2]};
  endfunction

  function automatic logic [2:0] ref_update(input logic [2:0] st, input logic [1:0] w);
    case (w)
      2'd0: return st | 3'b011;
      2'd1: return (st & 3'b101) | 3'b001;
      2'd2: return (st & 3'b010) | 3'b100;
      default: return st & 3'b010;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One IDLE-state cycle: drive, check at negedge, record accepted request.
  task automatic cycle(input logic v, input int idx, input logic upd, input int way,
                       input logic fl, input logic exp_ready);
    exp_t e;
    logic [S_INDEX-1:0] ix;
    ix = idx[S_INDEX-1:0];
    bus.req_valid  = v;
    bus.req_index  = ix;
    bus.req_update = upd;
    bus.req_way    = way[1:0];
    bus.flush_req  = fl;
    @(negedge clk);
    chk("req_ready", bus.req_ready, exp_ready);
    chk("lru_csb0", bus.lru_csb0, !(v && exp_ready));
    chk("flush_busy_idle", bus.flush_busy, 1'b0);
    chk("flush_done_idle", bus.flush_done, 1'b0);
    if (v && exp_ready) chk("lru_addr0", bus.lru_addr0, ix);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_valid", bus.rsp_valid, 1'b1);
      chk("rsp_victim", bus.rsp_victim, e.victim);
      if (e.upd) begin
        chk("wr_csb1", bus.lru_csb1, 1'b0);
        chk("wr_web1", bus.lru_web1, 1'b0);
        chk("wr_addr1", bus.lru_addr1, e.idx);
        chk("wr_din1", bus.lru_din1, e.din);
      end else begin
        chk("nowr_csb1", bus.lru_csb1, 1'b1);
        chk("nowr_web1", bus.lru_web1, 1'b1);
      end
    end else begin
      chk("rsp_valid_idle", bus.rsp_valid, 1'b0);
      chk("idle_csb1", bus.lru_csb1, 1'b1);
    end
    if (v && exp_ready) begin
      e.victim = ref_victim(ref_st[ix]);
      e.upd    = upd;
      e.idx    = ix;
      e.din    = ref_update(ref_st[ix], way[1:0]);
      if (upd) ref_st[ix] = e.din;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Flush sweep cycles; abort_at < NUM_SETS applies reset at that counter value.
  task automatic flush_sweep(input int abort_at);
    for (int k = 0; k < NUM_SETS; k++) begin
      bus.req_valid = 1'b1;
      bus.req_index = 4'd4;
      bus.flush_req = (k == 3);
      if (k == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", bus.req_ready, 1'b0);
        chk("abort_flush_done", bus.flush_done, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        bus.flush_req = 1'b0;
        @(negedge clk);
        chk("post_abort_busy", bus.flush_busy, 1'b0);
        chk("post_abort_done", bus.flush_done, 1'b0);
        chk("post_abort_csb1", bus.lru_csb1, 1'b1);
        chk("post_abort_ready", bus.req_ready, 1'b1);
        @(posedge clk);
        #1;
        for (int s = 0; s < abort_at; s++) ref_st[s] = 3'b000;
        return;
      end
      @(negedge clk);
      chk("flush_busy", bus.flush_busy, 1'b1);
      chk("flush_ready", bus.req_ready, 1'b0);
      chk("flush_csb0", bus.lru_csb0, 1'b1);
      chk("flush_csb1", bus.lru_csb1, 1'b0);
      chk("flush_web1", bus.lru_web1, 1'b0);
      chk("flush_addr1", bus.lru_addr1, k);
      chk("flush_din1", bus.lru_din1, 3'b000);
      chk("flush_done", bus.flush_done, (k == NUM_SETS - 1));
      chk("flush_rsp_valid", bus.rsp_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    bus.flush_req = 1'b0;
    for (int s = 0; s < NUM_SETS; s++) ref_st[s] = 3'b000;
  endtask

  initial begin
    bus.req_valid  = 1'b1;
    bus.req_index  = '0;
    bus.req_update = 1'b0;
    bus.req_way    = '0;
    bus.flush_req  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_flush_busy", bus.flush_busy, 1'b0);
    chk("rst_flush_done", bus.flush_done, 1'b0);
    chk("rst_csb0", bus.lru_csb0, 1'b1);
    chk("rst_csb1", bus.lru_csb1, 1'b1);
    chk("rst_web1", bus.lru_web1, 1'b1);
    chk("web0", bus.lru_web0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fresh set lookup.
    cycle(1, 5, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Back-to-back updates to set 3, then lookup (victims 0, 2, 1, 3).
    cycle(1, 3, 1, 0, 0, 1);
    cycle(1, 3, 1, 2, 0, 1);
    cycle(1, 3, 1, 1, 0, 1);
    cycle(1, 3, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Alternating updates to sets 7 and 8, no stalls.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) cycle(1, 7, 1, 3, 0, 1);
      else            cycle(1, 8, 1, 0, 0, 1);
    end
    cycle(1, 7, 0, 0, 0, 1);
    cycle(1, 8, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Mixed traffic.
    for (int i = 0; i < 24; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, NUM_SETS - 1),
            $urandom_range(0, 1), $urandom_range(0, 3), 0, 1);
    end
    cycle(0, 0, 0, 0, 0, 1);

    // Flush while an update to set 2 is in S2.
    cycle(1, 2, 1, 1, 0, 1);
    cycle(1, 9, 1, 0, 1, 0);
    flush_sweep(NUM_SETS);
    cycle(1, 2, 0, 0, 0, 1);
    cycle(1, 3, 0, 0, 0, 1);
    cycle(1, 8, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Reset during a flush at counter 6.
    cycle(1, 10, 1, 0, 0, 1);
    cycle(1, 1, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0);
    flush_sweep(6);
    cycle(1, 10, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
